// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: byte queue between the MEM stage and the UART transmitter; launches one frame at a time.
// Optional status word (sent counter, flags, fill level) is built only when UART_TXQ_STATUS_EN is defined.
module uart_tx_scheduler #(
   parameter int DEPTH      = 16,
   parameter int GAP_CYCLES = 0
) (
   input  logic        sysclk,
   input  logic        cpu_resetn,
   input  logic        wr_en,
   input  logic [7:0]  wr_data,
   output logic        stall_req,
   output logic        uart_wr_o,
   output logic [7:0]  uart_dat_o,
   input  logic        uart_busy_i,
   output logic        full,
   output logic        empty,
   output logic [31:0] status_o
);

   localparam int          AW        = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);
   localparam logic [7:0]  GAP_LOAD  = 8'(GAP_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_ARM,
      S_DRAIN,
      S_GAP
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          wr_q, wr_d;
   logic [7:0]    dat_q, dat_d;
   logic [7:0]    gap_q, gap_d;
   logic [7:0]    mem_q [DEPTH];
   logic          push;
   logic          pop;

   // Push admission looks only at the registered full flag, so a same-cycle pop never frees a slot early.
   assign push = wr_en && !full_q;
   assign pop  = (state_q == S_LAUNCH);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (pop) begin
         rptr_d = rptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      full_d  = (count_d == DEPTH_CNT);
      empty_d = (count_d == '0);
   end

   // IDLE also launches on a push into an empty queue, bypassing the array, to give one-cycle latency.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      dat_d   = dat_q;
      wr_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty_q || push) begin
               state_d = S_LAUNCH;
               wr_d    = 1'b1;
               dat_d   = empty_q ? wr_data : mem_q[rptr_q];
            end
         end
         S_LAUNCH: begin
            state_d = S_ARM;
         end
         S_ARM: begin
            state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (!uart_busy_i) begin
               if (GAP_LOAD != 8'd0) begin
                  state_d = S_GAP;
                  gap_d   = GAP_LOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_GAP: begin
            gap_d = gap_q - 8'd1;
            if (gap_q <= 8'd1) begin
               state_d = S_IDLE;
               gap_d   = 8'd0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (!cpu_resetn) begin
         state_q <= S_IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         wr_q    <= 1'b0;
         dat_q   <= 8'h00;
         gap_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         wr_q    <= wr_d;
         dat_q   <= dat_d;
         gap_q   <= gap_d;
      end
   end

   // Storage carries no reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge sysclk) begin
      if (push) begin
         mem_q[wptr_q] <= wr_data;
      end
   end

   assign stall_req  = wr_en & full_q;
   assign uart_wr_o  = wr_q;
   assign uart_dat_o = dat_q;
   assign full       = full_q;
   assign empty      = empty_q;

`ifdef UART_TXQ_STATUS_EN
   logic [15:0] sent_cnt_q, sent_cnt_d;

   always_comb begin
      sent_cnt_d = sent_cnt_q;
      if (pop) begin
         sent_cnt_d = sent_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge sysclk) begin
      if (!cpu_resetn) begin
         sent_cnt_q <= 16'h0000;
      end else begin
         sent_cnt_q <= sent_cnt_d;
      end
   end

   assign status_o = {sent_cnt_q, full_q, empty_q, 5'b00000, 9'(count_q)};
`else
   assign status_o = 32'h0000_0000;
`endif

endmodule
